// File: rtl/arm_pipe_pkg.sv
// Shared constants for the 5-stage ARM pipeline: instruction width, NOP encoding,
// PC step and default reset vector, plus a saturating counter helper.
package arm_pipe_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int unsigned WORD_INC         = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: load (redirect, word-aligned), hold, or step by one word.
// Latency: new PC visible one edge after the request; o_pc_inc is combinational.
// Backpressure: i_hold freezes the PC; i_load overrides i_hold.
module pc_reg
  import arm_pipe_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_hold,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_inc
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_target;

  // Low address bits of a redirect are dropped silently; no misalignment trap.
  assign w_target = i_load_addr & ALIGN_MASK;
  assign o_pc_inc = r_pc + ADDR_W'(WORD_INC);
  assign o_pc     = r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= w_target;
    end else if (!i_hold) begin
      r_pc <= o_pc_inc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC drives combinational imem, word + PC+4 land in IF/ID.
// Latency: one edge from PC==A to instruction A in IF/ID; redirect costs one bubble.
// Backpressure: freeze holds PC and IF/ID; branch_taken flushes IF/ID. Perf counters under IF_PERF_CNT_EN.
module fetch_stage
  import arm_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        bubble_cnt
);

  logic [ADDR_W-1:0]  w_pc;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic               w_advance;
  logic [ADDR_W-1:0]  r_if_id_pc;
  logic [INSTR_W-1:0] r_if_id_instr;
  logic               r_if_id_valid;

  assign w_advance = !branch_taken && !freeze;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (ADDR_W'(RESET_PC))
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (branch_taken),
    .i_load_addr (branch_addr),
    .i_hold      (freeze),
    .o_pc        (w_pc),
    .o_pc_inc    (w_pc_inc)
  );

  assign imem_addr = w_pc;

  // The word returned for the current PC is dropped when a redirect arrives.
  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (w_advance) begin
      r_if_id_pc    <= w_pc_inc;
      r_if_id_instr <= imem_instr;
      r_if_id_valid <= 1'b1;
    end
  end

  assign if_id_pc    = r_if_id_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (w_advance) begin
      r_fetch_cnt  <= sat_inc32(r_fetch_cnt);
    end else begin
      r_bubble_cnt <= sat_inc32(r_bubble_cnt);
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (reset vector 0 and near the top of memory)
// checked every cycle against a spec-level model, plus literal spot checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;

  logic [31:0] imem_addr   [2];
  logic [31:0] imem_instr  [2];
  logic [31:0] if_id_pc    [2];
  logic [31:0] if_id_instr [2];
  logic        if_id_valid [2];
  logic [31:0] fetch_cnt   [2];
  logic [31:0] bubble_cnt  [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  localparam logic [31:0] RPC [2] = '{32'h0000_0000, 32'hFFFF_FFF8};

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_instr[0] = memf(imem_addr[0]);
  assign imem_instr[1] = memf(imem_addr[1]);

  fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut0 (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr[0]), .imem_instr(imem_instr[0]),
    .if_id_pc(if_id_pc[0]), .if_id_instr(if_id_instr[0]), .if_id_valid(if_id_valid[0]),
    .fetch_cnt(fetch_cnt[0]), .bubble_cnt(bubble_cnt[0])
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .ADDR_W(32)) dut1 (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr[1]), .imem_instr(imem_instr[1]),
    .if_id_pc(if_id_pc[1]), .if_id_instr(if_id_instr[1]), .if_id_valid(if_id_valid[1]),
    .fetch_cnt(fetch_cnt[1]), .bubble_cnt(bubble_cnt[1])
  );

  // Spec-level model state, one set per instance.
  logic [31:0] m_pc [2], m_ifpc [2], m_instr [2], m_fetch [2], m_bubble [2];
  logic        m_valid [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k] = RPC[k]; m_ifpc[k] = 0; m_instr[k] = 0; m_valid[k] = 0;
        m_fetch[k] = 0; m_bubble[k] = 0;
      end else if (branch_taken || freeze) begin
        if (branch_taken) begin
          m_pc[k] = {branch_addr[31:2], 2'b00};
          m_ifpc[k] = 0; m_instr[k] = 0; m_valid[k] = 0;
        end
`ifdef IF_PERF_CNT_EN
        if (m_bubble[k] != 32'hFFFF_FFFF) m_bubble[k] = m_bubble[k] + 1;
`endif
      end else begin
        m_instr[k] = memf(m_pc[k]);
        m_ifpc[k]  = m_pc[k] + 4;
        m_valid[k] = 1'b1;
        m_pc[k]    = m_pc[k] + 4;
`ifdef IF_PERF_CNT_EN
        if (m_fetch[k] != 32'hFFFF_FFFF) m_fetch[k] = m_fetch[k] + 1;
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge once the model has seen a reset edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("imem_addr[%0d]", k),   imem_addr[k],   m_pc[k]);
        check($sformatf("if_id_pc[%0d]", k),    if_id_pc[k],    m_ifpc[k]);
        check($sformatf("if_id_instr[%0d]", k), if_id_instr[k], m_instr[k]);
        check($sformatf("if_id_valid[%0d]", k), 32'(if_id_valid[k]), 32'(m_valid[k]));
        check($sformatf("fetch_cnt[%0d]", k),   fetch_cnt[k],   m_fetch[k]);
        check($sformatf("bubble_cnt[%0d]", k),  bubble_cnt[k],  m_bubble[k]);
      end
    end
  end

  task automatic cyc(input logic r, input logic f, input logic b, input logic [31:0] a);
    rst = r; freeze = f; branch_taken = b; branch_addr = a;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_f, exp_b;

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    cyc(1, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0);
    // Reset state
    check("rst_imem_addr", imem_addr[0], 32'h0);
    check("rst_valid", 32'(if_id_valid[0]), 32'h0);
    check("rst_instr", if_id_instr[0], 32'h0);
    check("rst_hi_imem_addr", imem_addr[1], 32'hFFFF_FFF8);

    cyc(0, 0, 0, 0);                       // 1st advance
    check("first_if_id_pc", if_id_pc[0], 32'h4);
    check("first_if_id_instr", if_id_instr[0], memf(32'h0));
    check("first_valid", 32'(if_id_valid[0]), 32'h1);
    check("hi_pc_fffc", imem_addr[1], 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);                       // 2nd
    check("hi_pc_wrap", imem_addr[1], 32'h0000_0000);
    check("hi_ifpc_wrap", if_id_pc[1], 32'h0000_0000);
    check("seq_imem_8", imem_addr[0], 32'h8);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);                       // 5th advance
    check("seq_imem_20", imem_addr[0], 32'h14);
    check("seq_if_id_pc_20", if_id_pc[0], 32'h14);
    check("seq_instr_16", if_id_instr[0], memf(32'h10));
`ifdef IF_PERF_CNT_EN
    exp_f = 5;
`else
    exp_f = 0;
`endif
    check("fetch_cnt_5", fetch_cnt[0], exp_f);

    // Redirect to 4, advance to pc=8, then freeze 3 cycles
    cyc(0, 0, 1, 32'h4);
    check("br_flush_valid", 32'(if_id_valid[0]), 32'h0);
    cyc(0, 0, 0, 0);
    check("pc_at_8", imem_addr[0], 32'h8);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      check("frz_imem_addr", imem_addr[0], 32'h8);
      check("frz_if_id_pc", if_id_pc[0], 32'h8);
      check("frz_instr", if_id_instr[0], memf(32'h4));
    end
`ifdef IF_PERF_CNT_EN
    exp_b = 4;
`else
    exp_b = 0;
`endif
    check("bubble_cnt_4", bubble_cnt[0], exp_b);
    cyc(0, 0, 0, 0);
    check("resume_imem_12", imem_addr[0], 32'hC);
    check("resume_if_id_pc", if_id_pc[0], 32'hC);

    // Branch with freeze, misaligned target
    cyc(0, 1, 1, 32'h93);
    check("br_frz_pc", imem_addr[0], 32'h90);
    check("br_frz_valid", 32'(if_id_valid[0]), 32'h0);
    check("br_frz_instr", if_id_instr[0], 32'h0);
    cyc(0, 0, 0, 0);
    check("br_target_ifpc", if_id_pc[0], 32'h94);
    check("br_target_instr", if_id_instr[0], memf(32'h90));

    // Reset together with branch
    cyc(1, 1, 1, 32'h40);
    check("rst_br_pc", imem_addr[0], 32'h0);
    check("rst_br_hi_pc", imem_addr[1], 32'hFFFF_FFF8);
    check("rst_br_fetch", fetch_cnt[0], 32'h0);
    check("rst_br_bubble", bubble_cnt[0], 32'h0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("post_rst_pc", imem_addr[0], 32'h8);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
